// File: rtl/qe_pkg.sv
// Shared constants, FSM encoding and quadrature step helper for the qe_decode block.
package qe_pkg;

    localparam int FILT_LEN_DEF = 3;
    localparam int CNT_W        = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Next {i,q} pair one forward step along the Gray sequence 00->10->11->01->00.
    function automatic logic [1:0] fwd_next(input logic [1:0] p);
        case (p)
            2'b00:   fwd_next = 2'b10;
            2'b10:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b01;
            default: fwd_next = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/qe_glitch.sv
// One quadrature channel: 2-flop synchronizer followed by a FILT_LEN-clock persistence filter.
module qe_glitch
    import qe_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d_raw,
    input  logic hold,
    input  logic load,
    output logic acc,
    output logic chg
);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        s1_d  = d_raw;
        s2_d  = s1_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        chg   = 1'b0;
        if (hold) begin
            cnt_d = '0;
            if (load) acc_d = s2_q;
        end else if (s2_q == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
            acc_d = s2_q;
            cnt_d = '0;
            chg   = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            acc_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/qe_decode.sv
// Quadrature decoder: filtered I/Q channels, INIT/RUN sequencing, registered up/dn/err strobes.
module qe_decode
    import qe_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic clr_n,
    input  logic i,
    input  logic q,
    input  logic err_clr,
    output logic up,
    output logic dn,
    output logic err,
    output logic err_sticky,
    output logic ai,
    output logic aq
);

    state_e      state_q, state_d;
    logic [1:0]  init_cnt_q, init_cnt_d;
    logic        up_q, up_d;
    logic        dn_q, dn_d;
    logic        err_q, err_d;
    logic        sticky_q, sticky_d;
    logic        chg_i, chg_q;
    logic        hold, load;
    logic [1:0]  old_pair, new_pair;

    // Filters stay cleared for the whole INIT phase; the last INIT clock loads the accepted levels.
    assign hold     = (state_q == ST_INIT);
    assign load     = hold && (init_cnt_q == 2'd2);
    assign old_pair = {ai, aq};
    assign new_pair = {ai ^ chg_i, aq ^ chg_q};

    qe_glitch #(.FILT_LEN(FILT_LEN)) u_glitch_i (
        .clk   (clk),
        .clr_n (clr_n),
        .d_raw (i),
        .hold  (hold),
        .load  (load),
        .acc   (ai),
        .chg   (chg_i)
    );

    qe_glitch #(.FILT_LEN(FILT_LEN)) u_glitch_q (
        .clk   (clk),
        .clr_n (clr_n),
        .d_raw (q),
        .hold  (hold),
        .load  (load),
        .acc   (aq),
        .chg   (chg_q)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        up_d       = 1'b0;
        dn_d       = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == 2'd2) begin
                    state_d    = ST_RUN;
                    init_cnt_d = 2'd0;
                end else begin
                    init_cnt_d = init_cnt_q + 2'd1;
                end
            end
            default: begin
                if (chg_i && chg_q) begin
                    err_d = 1'b1;
                end else if (chg_i || chg_q) begin
                    up_d = (new_pair == fwd_next(old_pair));
                    dn_d = (old_pair == fwd_next(new_pair));
                end
            end
        endcase
        // A coincident clear loses against a fresh error.
        sticky_d = err_q | (sticky_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= 2'd0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
        end
    end

    assign up         = up_q;
    assign dn         = dn_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_qe_decode.sv
// Self-checking bench for qe_decode: table-driven level steps plus a strobe scoreboard.
module tb_qe_decode;

    typedef enum logic [1:0] {K_NONE = 2'd0, K_UP = 2'd1, K_DN = 2'd2, K_ERR = 2'd3} kind_e;

    typedef struct {
        int    cyc;
        kind_e kind;
    } sb_t;

    typedef struct {
        logic       i;
        logic       q;
        int         hold;
        kind_e      exp;
        bit         chk;
        logic [1:0] exp_pair;
    } vec_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic i = 1'b0;
    logic q = 1'b0;
    logic err_clr = 1'b0;
    logic up, dn, err, err_sticky, ai, aq;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    sb_t sb[$];
    vec_t vecs[12];

    qe_decode #(.FILT_LEN(3)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .i          (i),
        .q          (q),
        .err_clr    (err_clr),
        .up         (up),
        .dn         (dn),
        .err        (err),
        .err_sticky (err_sticky),
        .ai         (ai),
        .aq         (aq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Raw change driven now (cycle k) is first sampled at edge k+1; its strobe follows edge k+5.
    task automatic drive(input logic ni, input logic nq, input kind_e exp);
        sb_t e;
        i = ni;
        q = nq;
        if (exp != K_NONE) begin
            e.cyc  = cyc + 5;
            e.kind = exp;
            sb.push_back(e);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        kind_e obs;
        sb_t   e;
        if (up || dn || err) begin
            obs = up ? K_UP : (dn ? K_DN : K_ERR);
            check("strobe_onehot", $countones({up, dn, err}), 1);
            if (sb.size() == 0) begin
                check("unexpected_strobe", int'(obs), int'(K_NONE));
            end else begin
                e = sb.pop_front();
                check("strobe_kind", int'(obs), int'(e.kind));
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8, K_UP,   1'b1, 2'b10};
        vecs[1]  = '{1'b1, 1'b1, 8, K_UP,   1'b1, 2'b11};
        vecs[2]  = '{1'b0, 1'b1, 8, K_UP,   1'b1, 2'b01};
        vecs[3]  = '{1'b0, 1'b0, 8, K_UP,   1'b1, 2'b00};
        vecs[4]  = '{1'b0, 1'b1, 8, K_DN,   1'b1, 2'b01};
        vecs[5]  = '{1'b1, 1'b1, 8, K_DN,   1'b1, 2'b11};
        vecs[6]  = '{1'b1, 1'b0, 8, K_DN,   1'b1, 2'b10};
        vecs[7]  = '{1'b0, 1'b0, 8, K_DN,   1'b1, 2'b00};
        vecs[8]  = '{1'b1, 1'b0, 2, K_NONE, 1'b1, 2'b00};
        vecs[9]  = '{1'b0, 1'b0, 8, K_NONE, 1'b1, 2'b00};
        vecs[10] = '{1'b1, 1'b0, 3, K_UP,   1'b0, 2'b00};
        vecs[11] = '{1'b0, 1'b0, 8, K_DN,   1'b1, 2'b00};

        // Reset with both channels high: outputs cleared, then INIT loads 11 silently.
        i = 1'b1;
        q = 1'b1;
        #3;
        check("reset_outputs", int'({up, dn, err, err_sticky, ai, aq}), 0);
        wait_clk(2);
        @(negedge clk) clr_n = 1'b1;
        wait_clk(6);
        check("init_pair_11", int'({ai, aq}), 3);
        check("init_sticky", int'(err_sticky), 0);

        // Asynchronous reset clears the accepted levels immediately.
        clr_n = 1'b0;
        i = 1'b0;
        q = 1'b0;
        #1;
        check("reset_async_clear", int'({up, dn, err, err_sticky, ai, aq}), 0);
        @(negedge clk) clr_n = 1'b1;
        wait_clk(6);
        check("init_pair_00", int'({ai, aq}), 0);

        // Forward, reverse and glitch steps.
        foreach (vecs[n]) begin
            drive(vecs[n].i, vecs[n].q, vecs[n].exp);
            wait_clk(vecs[n].hold);
            if (vecs[n].chk) check($sformatf("pair_step%0d", n), int'({ai, aq}), int'(vecs[n].exp_pair));
        end
        check("table_sb_empty", sb.size(), 0);

        // Both channels change together: error strobe, sticky set, levels follow.
        drive(1'b1, 1'b1, K_ERR);
        wait_clk(8);
        check("err_pair_11", int'({ai, aq}), 3);
        check("err_sticky_set", int'(err_sticky), 1);
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        check("err_sticky_cleared", int'(err_sticky), 0);

        // Clear coinciding with the err strobe: set wins.
        drive(1'b0, 1'b0, K_ERR);
        wait_clk(5);
        check("err_strobe_live", int'(err), 1);
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        check("err_set_wins", int'(err_sticky), 1);
        wait_clk(4);
        check("err_pair_00", int'({ai, aq}), 0);
        check("err_sb_empty", sb.size(), 0);

        // Reset in the middle of filtering i: partial count discarded, no strobe afterwards.
        drive(1'b1, 1'b0, K_NONE);
        wait_clk(4);
        clr_n = 1'b0;
        #1;
        check("midfilt_reset_clear", int'({up, dn, err, err_sticky, ai, aq}), 0);
        @(negedge clk) clr_n = 1'b1;
        wait_clk(10);
        check("midfilt_init_pair", int'({ai, aq}), 2);
        check("midfilt_sticky", int'(err_sticky), 0);
        check("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qe_decode.md
QE_DECODE -- requirements
Module: qe_decode

Interface
REQ-001 Parameter FILT_LEN, default 3, is the number of consecutive clocks a synchronized channel must differ from its accepted value before that value is accepted; legal range 1..15.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port clr_n  input  1  reset, asynchronous, active-low.
REQ-004 Port i  input  1  raw quadrature channel I, asynchronous to clk.
REQ-005 Port q  input  1  raw quadrature channel Q, asynchronous to clk.
REQ-006 Port err_clr  input  1  synchronous clear of err_sticky.
REQ-007 Port up  output  1  one-clock strobe, one forward step.
REQ-008 Port dn  output  1  one-clock strobe, one reverse step.
REQ-009 Port err  output  1  one-clock strobe, illegal transition (both channels changed together).
REQ-010 Port err_sticky  output  1  latched err, held until err_clr.
REQ-011 Port ai  output  1  accepted (filtered) I level, for the downstream counter.
REQ-012 Port aq  output  1  accepted (filtered) Q level, for the downstream counter.

Function
REQ-013 Each channel SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-014 Per channel: if s2 equals the accepted value, the filter counter SHALL return to 0; if s2 differs and the counter equals FILT_LEN-1, the accepted value SHALL load s2 and the counter SHALL return to 0; otherwise the counter SHALL increment.
REQ-015 A raw edge first sampled at edge 1 and held stable SHALL update the accepted value at edge 2+FILT_LEN; the strobe SHALL be high for the cycle following that edge.
REQ-016 Pulses shorter than FILT_LEN clocks after synchronization SHALL be rejected with no change to ai/aq and no strobe.
REQ-017 Decode on the accepted pair {ai,aq} old->new: 00->10, 10->11, 11->01 and 01->00 SHALL assert up; the reverse of each SHALL assert dn.
REQ-018 If both channels accept at the same edge, err SHALL be asserted, both accepted values SHALL update, and up/dn SHALL stay low.
REQ-019 up, dn and err SHALL be mutually exclusive and SHALL be registered.
REQ-020 The FSM SHALL have states INIT and RUN; INIT SHALL last 2 clocks after clr_n deasserts, then load ai/aq directly from s2 with no strobe and move to RUN.
REQ-021 In INIT the filters SHALL be held at 0 and up/dn/err SHALL be low.
REQ-022 err_sticky SHALL set on err; if err and err_clr coincide, set SHALL win.

Reset
REQ-023 While clr_n is low: s1, s2, ai, aq, filter counters, up, dn, err and err_sticky SHALL be 0, and the FSM SHALL be in INIT.
REQ-024 Assertion of clr_n mid-filter SHALL discard the partial count, with no strobe on release.

Structure
REQ-025 Shared package qe_pkg SHALL hold the FILT_LEN default, the filter counter width (4), and the FSM state encoding (INIT=0, RUN=1).
REQ-026 The synchronizer plus filter SHALL be one sub-module, qe_glitch, instantiated once per channel; decode, FSM and sticky logic stay in qe_decode.

Verification
REQ-027 FILT_LEN=3, reset released with i=q=1 -> after INIT ai=aq=1, no up/dn/err strobe.
REQ-028 From 00, drive forward 00->10->11->01->00, each level held 8 clocks -> exactly 4 up strobes, each at edge 5 after its raw change, and no dn.
REQ-029 From 00, drive the same sequence reversed -> exactly 4 dn strobes, no up.
REQ-030 From 00, 2-clock glitch on i (FILT_LEN=3) -> ai stays 0 and no strobe; a 3-clock glitch -> ai=1, then back to 0, giving one up then one dn.
REQ-031 i and q toggled 00->11 on the same clock -> one err strobe, err_sticky=1, ai=aq=1, no up/dn; err_clr pulse -> err_sticky=0.
REQ-032 clr_n pulsed low with i's filter count at 2 -> all outputs 0 immediately, INIT re-entered, no strobe after release.
